gcd_request_scheduler: RTL and testbench

- Shares one Greatest_Common_Divisor engine among 4 requesters using round-robin arbitration.
- Accepts one operand pair at a time and sequences the engine's start/done handshake.
- Resolves zero-operand requests locally, because the engine never terminates on zero operands.
- Returns each result tagged with the requester id; a watchdog latches a fault if the engine stalls.

---
 rtl/gcd_request_scheduler.sv | 133 +++++++++++++
 tb/tb_gcd_request_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_request_scheduler.sv
// gcd_request_scheduler: round-robin sharing of one GCD engine among four requesters,
// with local zero-operand bypass and a sticky watchdog fault on engine stall.
module gcd_request_scheduler #(
  parameter int W = 16,
  parameter int TIMEOUT = 70000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] a_in,
  input  logic [4*W-1:0] b_in,
  output logic [3:0]     ack,
  output logic           rsp_valid,
  output logic [1:0]     rsp_id,
  output logic [W-1:0]   rsp_gcd,
  output logic           rsp_err,
  output logic           fault,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_gcd
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DRAIN, RESP, FAULT} state_t;
  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, rsp_gcd_q, rsp_gcd_d, ga, gb;
  logic           rsp_err_q, rsp_err_d, fault_q, fault_d, found;
  logic [TW-1:0]  timer_q, timer_d;
  // first requesting index at or after ptr, wrapping mod 4
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        gnt = ptr_q + 2'(k);
      end
    end
    ga = a_in[gnt*W +: W];
    gb = b_in[gnt*W +: W];
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    rsp_id_d = rsp_id_q;
    rsp_gcd_d = rsp_gcd_q;
    rsp_err_d = rsp_err_q;
    fault_d = fault_q;
    timer_d = timer_q;
    ack = 4'b0;
    case (state_q)
      IDLE: if (found) begin
        ack[gnt] = 1'b1;
        id_d = gnt;
        a_d = ga;
        b_d = gb;
        if (ga == '0 || gb == '0) begin
          rsp_id_d = gnt;
          rsp_gcd_d = ga | gb;
          rsp_err_d = (ga == '0 && gb == '0);
          state_d = RESP;
        end else state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: if (eng_done) begin
        res_d = eng_gcd;
        state_d = DRAIN;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        rsp_id_d = id_q;
        rsp_gcd_d = '0;
        rsp_err_d = 1'b1;
        fault_d = 1'b1;
        state_d = RESP;
      end else timer_d = timer_q + TW'(1);
      // hold off until the engine has dropped done and is idle again
      DRAIN: if (!eng_done) begin
        rsp_id_d = id_q;
        rsp_gcd_d = res_q;
        rsp_err_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        ptr_d = id_q + 2'd1;
        state_d = fault_q ? FAULT : IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      rsp_id_q <= '0;
      rsp_gcd_q <= '0;
      rsp_err_q <= 1'b0;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      rsp_id_q <= rsp_id_d;
      rsp_gcd_q <= rsp_gcd_d;
      rsp_err_q <= rsp_err_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end
  assign rsp_valid = (state_q == RESP);
  assign rsp_id = rsp_id_q;
  assign rsp_gcd = rsp_gcd_q;
  assign rsp_err = rsp_err_q;
  assign fault = fault_q;
  assign eng_start = (state_q == ISSUE);
  assign eng_a = a_q;
  assign eng_b = b_q;
endmodule

// File: tb/tb_gcd_request_scheduler.sv
// tb_gcd_request_scheduler: randomized requesters plus an engine stub; a scoreboard
// predicts grant order and responses, and a negedge monitor checks them.
module tb_gcd_request_scheduler;
  localparam int W = 16;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [4*W-1:0] a_in = '0, b_in = '0;
  logic [3:0] ack;
  logic rsp_valid, rsp_err, fault, eng_start;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_gcd, eng_a, eng_b;
  logic eng_done = 1'b0;
  logic [W-1:0] eng_gcd = '0;

  gcd_request_scheduler #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .fault(fault), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_gcd(eng_gcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    logic [W-1:0] g, a, b;
    bit err, byp, to;
    int ac;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, rsp_cnt = 0, start_cnt = 0, ptr_m = 0;
  bit outst = 0, fault_m = 0;
  logic [3:0] ack_seen = '0;
  bit e_stall = 0;
  int e_lat = 3, e_cnt = 0, e_hold = 0;
  logic [W-1:0] e_res = '0;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  int g_m;
  exp_t e_m;
  always @(negedge clk) begin
    cyc++;
    ack_seen = ack;
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
      outst = 0;
      fault_m = 0;
    end else begin
      if (outst || fault_m || req == 0) chk("no_ack", ack, 4'b0);
      else begin
        g_m = -1;
        for (int k = 0; k < 4; k++)
          if (g_m < 0 && req[(ptr_m + k) % 4]) g_m = (ptr_m + k) % 4;
        chk("ack_grant", ack, 4'b1 << g_m);
        e_m.id = g_m;
        e_m.a = a_in[g_m*W +: W];
        e_m.b = b_in[g_m*W +: W];
        e_m.ac = cyc;
        e_m.byp = (e_m.a == 0 || e_m.b == 0);
        e_m.to = !e_m.byp && e_stall;
        e_m.err = (e_m.a == 0 && e_m.b == 0) || e_m.to;
        e_m.g = e_m.byp ? ((e_m.a == 0) ? e_m.b : e_m.a) : (e_m.to ? '0 : gcd_ref(e_m.a, e_m.b));
        q.push_back(e_m);
        outst = 1;
      end
      if (eng_start) begin
        start_cnt++;
        chk("start_while_done", eng_done, 0);
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL start_unexpected: eng_start with no granted request");
        end else begin
          chk("start_on_bypass", q[0].byp, 0);
          chk("eng_a", eng_a, q[0].a);
          chk("eng_b", eng_b, q[0].b);
          chk("start_lat", cyc, q[0].ac + 1);
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: rsp_valid id=%0d gcd=%0h with empty scoreboard", rsp_id, rsp_gcd);
        end else begin
          e_m = q.pop_front();
          chk("rsp_id", rsp_id, e_m.id);
          chk("rsp_gcd", rsp_gcd, e_m.g);
          chk("rsp_err", rsp_err, e_m.err);
          if (e_m.byp) chk("bypass_lat", cyc, e_m.ac + 1);
          if (e_m.to) begin
            chk("timeout_lat", cyc, e_m.ac + 2 + TO);
            fault_m = 1;
          end
          ptr_m = (e_m.id + 1) % 4;
          outst = 0;
        end
      end
      chk("fault", fault, fault_m);
    end
  end

  // engine stub: fixed latency per start, done held 1..3 cycles, stalls on demand
  bit st_s, rs_s;
  logic [W-1:0] ea_s, eb_s;
  initial forever begin
    @(negedge clk);
    st_s = eng_start; ea_s = eng_a; eb_s = eng_b; rs_s = rst_n;
    @(posedge clk); #1;
    if (!rs_s) begin
      e_cnt = 0;
      e_hold = 0;
    end else if (st_s) begin
      e_cnt = e_lat;
      e_res = gcd_ref(ea_s, eb_s);
    end else if (e_cnt > 0) begin
      if (!e_stall) begin
        e_cnt--;
        if (e_cnt == 0) e_hold = $urandom_range(1, 3);
      end
    end else if (e_hold > 0) e_hold--;
    eng_done = (e_hold > 0);
    eng_gcd = eng_done ? e_res : W'($urandom);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic serve(input int n, input int maxc, input bit drop);
    int s0, c;
    s0 = rsp_cnt;
    c = 0;
    while (rsp_cnt < s0 + n && c < maxc) begin
      tick();
      c++;
      if (drop) req = req & ~ack_seen;
    end
    if (rsp_cnt < s0 + n) begin
      tests++; fails++;
      $display("FAIL wait_rsp: got %0d responses, expected %0d", rsp_cnt - s0, n);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_gcd"}, rsp_gcd, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_fault"}, fault, 0);
    chk({nm, "_eng_start"}, eng_start, 0);
    chk({nm, "_eng_a"}, eng_a, 0);
    chk({nm, "_eng_b"}, eng_b, 0);
  endtask

  task automatic rand_op(input int i);
    int r, f;
    r = $urandom_range(0, 9);
    f = $urandom_range(1, 30);
    set_op(i, (r == 0 || r == 2) ? W'(0) : W'($urandom_range(1, 2000) * f),
              (r == 1 || r == 2) ? W'(0) : W'($urandom_range(1, 2000) * f));
  endtask

  initial begin
    int s0, c;
    rst_n = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1;
    // single request through the engine
    set_op(0, 48, 18);
    req = 4'b0001;
    serve(1, 50, 1);
    // round robin with all requests held
    for (int i = 0; i < 4; i++) set_op(i, 12, 8);
    req = 4'b1111;
    serve(5, 200, 0);
    req = 0;
    tick();
    // zero bypass
    s0 = start_cnt;
    set_op(2, 0, 35);
    req = 4'b0100;
    serve(1, 20, 1);
    set_op(2, 0, 0);
    req = 4'b0100;
    serve(1, 20, 1);
    chk("bypass_no_start", start_cnt, s0);
    // long computation
    e_lat = 10;
    set_op(0, 16'hffff, 1);
    req = 4'b0001;
    serve(1, 60, 1);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      e_lat = $urandom_range(1, 8);
      tick();
      req = req & ~ack_seen;
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          rand_op(i);
          req[i] = 1'b1;
        end
    end
    req = req & ~ack_seen;
    serve(0, 1, 1);
    c = 0;
    while ((req != 0 || outst) && c < 500) begin
      tick();
      req = req & ~ack_seen;
      c++;
    end
    chk("drained", q.size(), 0);
    // reset mid-BUSY, then grant order restarts from 0
    e_lat = 3;
    set_op(2, 9, 6);
    req = 4'b0100;
    serve(1, 50, 1);
    e_lat = 12;
    set_op(1, 30, 12);
    req = 4'b0010;
    s0 = start_cnt;
    c = 0;
    while (start_cnt == s0 && c < 20) begin
      tick();
      req = req & ~ack_seen;
      c++;
    end
    chk("abort_started", start_cnt, s0 + 1);
    repeat (3) tick();
    rst_n = 0;
    req = 0;
    tick();
    chk_zero("mid_reset");
    tick();
    rst_n = 1;
    e_lat = 3;
    set_op(1, 21, 14);
    set_op(3, 10, 4);
    req = 4'b1010;
    c = 0;
    while (ack_seen == 0 && c < 10) begin
      tick();
      c++;
    end
    chk("post_reset_grant", ack_seen, 4'b0010);
    req = req & ~ack_seen;
    serve(2, 60, 1);
    // watchdog timeout and sticky fault
    e_stall = 1;
    set_op(0, 5, 3);
    req = 4'b0001;
    serve(1, 60, 1);
    req = 4'b1111;
    repeat (30) tick();
    chk("fault_sticky", fault, 1);
    rst_n = 0;
    req = 0;
    e_stall = 0;
    repeat (2) tick();
    chk_zero("fault_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
